// File: rtl/rns_alu_seq.sv
// Sequential three-channel RNS ALU: binary operands are encoded to residues bit-serially,
// combined per channel (add/sub/mul/mac), then decoded back to binary by incremental CRT search.
module rns_alu_seq #(
  parameter int DATA_W = 8,
  parameter int MOD_W  = 4,
  localparam int RES_W = 3*MOD_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [MOD_W-1:0]  moduli_1,
  input  logic [MOD_W-1:0]  moduli_2,
  input  logic [MOD_W-1:0]  moduli_3,
  input  logic [1:0]        operation,
  input  logic              acc_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  result,
  output logic              err
);
  localparam int X_W = 3*MOD_W;
  localparam int SW  = $clog2(DATA_W + MOD_W + 1);
  localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_MAC = 2'd3;

  typedef enum logic [2:0] {IDLE, ENCODE, COMPUTE, DECODE, DONE} state_t;
  state_t state_reg, state_next;

  logic [MOD_W-1:0]  mod_in [3];
  logic [MOD_W-1:0]  mod_reg [3];
  logic [MOD_W-1:0]  ra_reg [3], rb_reg [3], sh_reg [3], prod_reg [3];
  logic [MOD_W-1:0]  tgt_reg [3], c_reg [3], acc_reg [3];
  logic [MOD_W-1:0]  ra_next [3], rb_next [3], prod_next [3], tgt_next [3];
  logic [MOD_W-1:0]  acc_next [3], c_next [3];
  logic [2:0]        hit, bad_in;
  logic [DATA_W-1:0] a_mag, b_mag, a_sh_reg, b_sh_reg;
  logic [1:0]        op_reg;
  logic              clr_reg, sign_reg, bad_reg, is_mul_in, match, enc_last, cmp_last;
  logic [SW-1:0]     step_reg;
  logic [X_W-1:0]    x_reg;

  // Single conditional subtract: valid whenever v < 2*m.
  function automatic logic [MOD_W-1:0] fold(input logic [MOD_W:0] v, input logic [MOD_W-1:0] m);
    if (v >= {1'b0, m}) return MOD_W'(v - {1'b0, m});
    return v[MOD_W-1:0];
  endfunction

  assign mod_in[0] = moduli_1;
  assign mod_in[1] = moduli_2;
  assign mod_in[2] = moduli_3;

  assign is_mul_in = (operation == OP_MUL);
  assign a_mag = (is_mul_in && a[DATA_W-1]) ? (~a + DATA_W'(1)) : a;
  assign b_mag = (is_mul_in && b[DATA_W-1]) ? (~b + DATA_W'(1)) : b;

  assign enc_last = (step_reg == SW'(DATA_W-1));
  assign cmp_last = (step_reg == SW'(MOD_W-1));
  assign match    = &hit;

  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    logic [MOD_W-1:0] dbl, mac_base, add_r, sub_r;
    assign bad_in[gi]  = (mod_in[gi] < MOD_W'(2));
    assign ra_next[gi] = fold({ra_reg[gi], a_sh_reg[DATA_W-1]}, mod_reg[gi]);
    assign rb_next[gi] = fold({rb_reg[gi], b_sh_reg[DATA_W-1]}, mod_reg[gi]);
    // Horner step over rb, MSB first: p = 2p + bit*ra (mod m)
    assign dbl           = fold({prod_reg[gi], 1'b0}, mod_reg[gi]);
    assign prod_next[gi] = fold({1'b0, dbl} + (sh_reg[gi][MOD_W-1] ? {1'b0, ra_reg[gi]} : '0),
                                mod_reg[gi]);
    assign mac_base     = clr_reg ? '0 : acc_reg[gi];
    assign acc_next[gi] = fold({1'b0, mac_base} + {1'b0, prod_next[gi]}, mod_reg[gi]);
    assign add_r = fold({1'b0, ra_reg[gi]} + {1'b0, rb_reg[gi]}, mod_reg[gi]);
    assign sub_r = fold({1'b0, ra_reg[gi]} + {1'b0, mod_reg[gi]} - {1'b0, rb_reg[gi]}, mod_reg[gi]);
    assign tgt_next[gi] = (op_reg == OP_ADD) ? add_r :
                          (op_reg == OP_SUB) ? sub_r :
                          (op_reg == OP_MUL) ? prod_next[gi] : acc_next[gi];
    assign c_next[gi] = (c_reg[gi] == mod_reg[gi] - MOD_W'(1)) ? '0 : c_reg[gi] + MOD_W'(1);
    assign hit[gi]    = (c_reg[gi] == tgt_reg[gi]);
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = ENCODE;
      ENCODE:  if (bad_reg) state_next = DONE;
               else if (enc_last) state_next = COMPUTE;
      COMPUTE: if (cmp_last) state_next = DECODE;
      DECODE:  if (match) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result   <= '0;
      err      <= 1'b0;
      step_reg <= '0;
      x_reg    <= '0;
      for (int i = 0; i < 3; i++) acc_reg[i] <= '0;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) begin
          op_reg   <= operation;
          clr_reg  <= acc_clr;
          sign_reg <= is_mul_in & (a[DATA_W-1] ^ b[DATA_W-1]);
          bad_reg  <= |bad_in;
          a_sh_reg <= a_mag;
          b_sh_reg <= b_mag;
          step_reg <= '0;
          for (int i = 0; i < 3; i++) begin
            mod_reg[i] <= mod_in[i];
            ra_reg[i]  <= '0;
            rb_reg[i]  <= '0;
          end
        end
        ENCODE: if (bad_reg) begin
          result <= '0;
          err    <= 1'b1;
        end else begin
          a_sh_reg <= a_sh_reg << 1;
          b_sh_reg <= b_sh_reg << 1;
          for (int i = 0; i < 3; i++) begin
            ra_reg[i] <= ra_next[i];
            rb_reg[i] <= rb_next[i];
          end
          if (enc_last) begin
            step_reg <= '0;
            for (int i = 0; i < 3; i++) begin
              sh_reg[i]   <= rb_next[i];
              prod_reg[i] <= '0;
            end
          end else begin
            step_reg <= step_reg + SW'(1);
          end
        end
        COMPUTE: begin
          for (int i = 0; i < 3; i++) begin
            prod_reg[i] <= prod_next[i];
            sh_reg[i]   <= sh_reg[i] << 1;
          end
          if (cmp_last) begin
            step_reg <= '0;
            x_reg    <= '0;
            for (int i = 0; i < 3; i++) begin
              tgt_reg[i] <= tgt_next[i];
              c_reg[i]   <= '0;
              if (op_reg == OP_MAC) acc_reg[i] <= acc_next[i];
            end
          end else begin
            step_reg <= step_reg + SW'(1);
          end
        end
        DECODE: if (match) begin
          err    <= 1'b0;
          result <= (op_reg == OP_MUL && sign_reg && x_reg != '0) ?
                    RES_W'(0) - {1'b0, x_reg} : {1'b0, x_reg};
        end else begin
          x_reg <= x_reg + X_W'(1);
          for (int i = 0; i < 3; i++) c_reg[i] <= c_next[i];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rns_alu_seq.sv
// Directed bench for rns_alu_seq: hand-computed results, latencies and handshake behaviour.
module tb_rns_alu_seq;
  localparam int DATA_W = 8;
  localparam int MOD_W  = 4;
  localparam int RES_W  = 13;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] a = '0;
  logic [DATA_W-1:0] b = '0;
  logic [MOD_W-1:0]  moduli_1 = 4'd7;
  logic [MOD_W-1:0]  moduli_2 = 4'd11;
  logic [MOD_W-1:0]  moduli_3 = 4'd13;
  logic [1:0]        operation = 2'd0;
  logic              acc_clr = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [RES_W-1:0]  result;
  logic              err;

  int               n_vec = 0;
  int               n_err = 0;
  logic [RES_W-1:0] res;
  logic             e;
  int               lat;
  logic             stable;

  rns_alu_seq #(.DATA_W(DATA_W), .MOD_W(MOD_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .moduli_1(moduli_1), .moduli_2(moduli_2), .moduli_3(moduli_3),
    .operation(operation), .acc_clr(acc_clr), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic start_op(input logic [1:0] op, input logic [7:0] av, input logic [7:0] bv,
                          input logic clr, input logic [3:0] m1, input logic [3:0] m2,
                          input logic [3:0] m3);
    int w = 0;
    while (!in_ready && w < 2000) begin
      @(posedge clk); #1; w++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    operation = op; a = av; b = bv; acc_clr = clr;
    moduli_1 = m1; moduli_2 = m2; moduli_3 = m3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, output logic [RES_W-1:0] r, output logic ev,
                           output int l);
    l = 0;
    while (!out_valid && l < 5000) begin
      @(posedge clk); #1; l++;
    end
    chk({tag, "_valid"}, out_valid, 1);
    r  = result;
    ev = err;
    $display("txn %s op=%0d a=%0h b=%0h m=%0d/%0d/%0d -> result=%0h err=%0b latency=%0d",
             tag, operation, a, b, moduli_1, moduli_2, moduli_3, r, ev, l);
  endtask

  task automatic handshake(input string tag);
    @(posedge clk); #1;
    chk({tag, "_hs_out_valid"}, out_valid, 0);
    chk({tag, "_hs_in_ready"}, in_ready, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_err", err, 0);
    chk("reset_in_ready", in_ready, 1);
    rst = 1'b0;

    // add 100+50 with out_ready already high
    start_op(2'd0, 8'd100, 8'd50, 1'b0, 4'd7, 4'd11, 4'd13);
    wait_done("add", res, e, lat);
    chk("add_result", res, 150);
    chk("add_err", e, 0);
    chk("add_latency", lat, 163);
    handshake("add");

    // sub wraps mod 1001
    start_op(2'd1, 8'd5, 8'd9, 1'b0, 4'd7, 4'd11, 4'd13);
    wait_done("sub", res, e, lat);
    chk("sub_result", res, 997);
    chk("sub_in_ready_done", in_ready, 0);
    chk("sub_latency", lat, 1010);
    handshake("sub");

    // signed multiply
    start_op(2'd2, 8'hFD, 8'd7, 1'b0, 4'd7, 4'd11, 4'd13);
    wait_done("mul_neg3x7", res, e, lat);
    chk("mul_neg3x7_result", res, 13'h1FEB);
    chk("mul_neg3x7_latency", lat, 34);
    handshake("mul_neg3x7");
    start_op(2'd2, 8'h80, 8'd1, 1'b0, 4'd7, 4'd11, 4'd13);
    wait_done("mul_min", res, e, lat);
    chk("mul_min_result", res, 13'h1F80);
    handshake("mul_min");

    // multiply-accumulate chain, reset clears accumulator
    start_op(2'd3, 8'd2, 8'd3, 1'b1, 4'd7, 4'd11, 4'd13);
    wait_done("mac_clr", res, e, lat);
    chk("mac_clr_result", res, 6);
    handshake("mac_clr");
    start_op(2'd3, 8'd4, 8'd5, 1'b0, 4'd7, 4'd11, 4'd13);
    wait_done("mac_acc", res, e, lat);
    chk("mac_acc_result", res, 26);
    handshake("mac_acc");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_result", result, 0);
    start_op(2'd3, 8'd1, 8'd1, 1'b0, 4'd7, 4'd11, 4'd13);
    wait_done("mac_after_rst", res, e, lat);
    chk("mac_after_rst_result", res, 1);
    handshake("mac_after_rst");

    // non-coprime moduli, lcm 60
    start_op(2'd0, 8'd50, 8'd20, 1'b0, 4'd4, 4'd6, 4'd5);
    wait_done("add_lcm60", res, e, lat);
    chk("add_lcm60_result", res, 10);
    handshake("add_lcm60");

    // bad modulus: immediate error, accumulator must survive
    start_op(2'd3, 8'd5, 8'd5, 1'b1, 4'd7, 4'd1, 4'd13);
    wait_done("bad_mod", res, e, lat);
    chk("bad_mod_err", e, 1);
    chk("bad_mod_result", res, 0);
    chk("bad_mod_latency", lat, 1);
    handshake("bad_mod");
    start_op(2'd3, 8'd0, 8'd0, 1'b0, 4'd7, 4'd11, 4'd13);
    wait_done("mac_acc_kept", res, e, lat);
    chk("mac_acc_kept_result", res, 1);
    chk("mac_acc_kept_err", e, 0);
    handshake("mac_acc_kept");

    // back-pressure in DONE
    out_ready = 1'b0;
    start_op(2'd0, 8'd3, 8'd4, 1'b0, 4'd7, 4'd11, 4'd13);
    wait_done("add_hold", res, e, lat);
    chk("add_hold_result", res, 7);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!(out_valid === 1'b1 && result === 13'd7 && err === 1'b0 && in_ready === 1'b0))
        stable = 1'b0;
    end
    chk("add_hold_stable", stable, 1);
    out_ready = 1'b1;
    handshake("add_hold");

    // reset in the middle of DECODE
    start_op(2'd1, 8'd5, 8'd9, 1'b0, 4'd7, 4'd11, 4'd13);
    repeat (100) @(posedge clk);
    #1;
    chk("abort_pre_out_valid", out_valid, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    start_op(2'd0, 8'd1, 8'd2, 1'b0, 4'd7, 4'd11, 4'd13);
    wait_done("add_after_abort", res, e, lat);
    chk("add_after_abort_result", res, 3);
    chk("add_after_abort_latency", lat, 16);
    handshake("add_after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
